sysid_access_arbiter: RTL and testbench

- Sits in front of the read-only system-ID slave: a combinational, zero-wait-state slave returning one 32-bit word per 1-bit address.
- After reset, reads both ID words, checks them against build-time expected values and publishes the result.
- Then shares the slave between two Avalon-MM read masters (e.g. CPU data master, JTAG debug master) under round-robin arbitration, with registered waitrequest and readdatavalid.

---
 rtl/sysid_access_arbiter.sv | 140 ++++++++++++++
 tb/tb_sysid_access_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_access_arbiter.sv
// Front-end for the read-only system-ID slave: checks both ID words after reset or
// on request, then shares the slave between two Avalon-MM read masters round-robin.
module sysid_access_arbiter #(
  parameter logic [31:0] EXPECTED_WORD0 = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_WORD1 = 32'h5547_181E
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        recheck,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  output logic        sys_address,
  input  logic [31:0] sys_readdata,
  output logic [31:0] id_word0,
  output logic [31:0] id_word1,
  output logic        id_valid,
  output logic        id_mismatch
);

  typedef enum logic [1:0] {CHK0, CHK1, IDLE, SERVE} state_t;

  state_t state, state_next;
  logic   grant, grant_next;
  logic   last_grant, last_grant_next;
  logic   recheck_pend, recheck_pend_next;
  logic   winner;
  logic   mm0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CHK0;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      recheck_pend <= 1'b0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      last_grant   <= last_grant_next;
      recheck_pend <= recheck_pend_next;
    end
  end

  // A recheck seen outside IDLE is remembered and wins over reads at the next IDLE.
  always_comb begin
    state_next        = state;
    grant_next        = grant;
    last_grant_next   = last_grant;
    recheck_pend_next = recheck_pend;
    sys_address       = 1'b0;
    winner            = 1'b0;
    case (state)
      CHK0: begin
        sys_address = 1'b0;
        state_next  = CHK1;
        if (recheck) recheck_pend_next = 1'b1;
      end
      CHK1: begin
        sys_address = 1'b1;
        state_next  = IDLE;
        if (recheck) recheck_pend_next = 1'b1;
      end
      IDLE: begin
        if (recheck || recheck_pend) begin
          state_next        = CHK0;
          recheck_pend_next = 1'b0;
        end else if (m0_read || m1_read) begin
          winner          = (m0_read && m1_read) ? ~last_grant : m1_read;
          grant_next      = winner;
          last_grant_next = winner;
          state_next      = SERVE;
        end
      end
      SERVE: begin
        sys_address = grant ? m1_address : m0_address;
        state_next  = IDLE;
        if (recheck) recheck_pend_next = 1'b1;
      end
      default: state_next = CHK0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      id_word0         <= '0;
      id_word1         <= '0;
      id_valid         <= 1'b0;
      id_mismatch      <= 1'b0;
      mm0              <= 1'b0;
    end else begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      case (state)
        CHK0: begin
          id_word0 <= sys_readdata;
          mm0      <= (sys_readdata != EXPECTED_WORD0);
        end
        CHK1: begin
          id_word1    <= sys_readdata;
          id_valid    <= 1'b1;
          id_mismatch <= mm0 | (sys_readdata != EXPECTED_WORD1);
        end
        IDLE: begin
          if (state_next == CHK0) begin
            id_valid <= 1'b0;
          end else if (state_next == SERVE) begin
            m0_waitrequest <= grant_next;
            m1_waitrequest <= ~grant_next;
          end
        end
        SERVE: begin
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          if (grant) begin
            m1_readdata      <= sys_readdata;
            m1_readdatavalid <= 1'b1;
          end else begin
            m0_readdata      <= sys_readdata;
            m0_readdatavalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Randomised bench for sysid_access_arbiter: a transaction-level model predicts every
// output each cycle, and directed scenarios pin the model with literal values.
module tb_sysid_access_arbiter;

  localparam logic [31:0] EXP0 = 32'h0000_0000;
  localparam logic [31:0] EXP1 = 32'h5547_181E;

  logic        clock = 1'b0;
  logic        reset, recheck;
  logic        m0_read, m0_address, m1_read, m1_address;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        sys_address;
  logic [31:0] sys_readdata;
  logic [31:0] id_word0, id_word1;
  logic        id_valid, id_mismatch;
  logic [31:0] slave_word [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  assign sys_readdata = slave_word[sys_address];

  sysid_access_arbiter #(.EXPECTED_WORD0(EXP0), .EXPECTED_WORD1(EXP1)) dut (
    .clock(clock), .reset(reset), .recheck(recheck),
    .m0_read(m0_read), .m0_address(m0_address), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_address(m1_address), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sys_address(sys_address), .sys_readdata(sys_readdata),
    .id_word0(id_word0), .id_word1(id_word1), .id_valid(id_valid), .id_mismatch(id_mismatch)
  );

  // Model: chk_idx = ID word being read (-1 none), serving = master in its data phase.
  int          chk_idx, serving, prefer;
  bit          pend, mis0, model_ready = 1'b0;
  bit          exp_wr [2];
  bit          exp_rdv [2];
  logic [31:0] exp_rd [2];
  logic [31:0] exp_word [2];
  bit          exp_valid, exp_mis;

  function automatic bit addr_of(int m);
    return (m == 1) ? m1_address : m0_address;
  endfunction

  function automatic bit exp_addr();
    if (chk_idx >= 0) return chk_idx[0];
    if (serving >= 0) return addr_of(serving);
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    logic [31:0] data;
    int w;
    data = slave_word[exp_addr()];
    if (reset) begin
      chk_idx = 0; serving = -1; pend = 0; prefer = 0; mis0 = 0;
      for (int m = 0; m < 2; m++) begin
        exp_wr[m] = 1; exp_rdv[m] = 0; exp_rd[m] = '0; exp_word[m] = '0;
      end
      exp_valid = 0; exp_mis = 0;
      model_ready = 1'b1;
    end else if (model_ready) begin
      exp_rdv[0] = 0; exp_rdv[1] = 0;
      if (chk_idx == 0) begin
        exp_word[0] = data; mis0 = (data != EXP0); chk_idx = 1;
        if (recheck) pend = 1;
      end else if (chk_idx == 1) begin
        exp_word[1] = data; exp_valid = 1; exp_mis = mis0 || (data != EXP1); chk_idx = -1;
        if (recheck) pend = 1;
      end else if (serving >= 0) begin
        exp_rd[serving] = data; exp_rdv[serving] = 1;
        exp_wr[0] = 1; exp_wr[1] = 1; serving = -1;
        if (recheck) pend = 1;
      end else if (recheck || pend) begin
        chk_idx = 0; pend = 0; exp_valid = 0;
      end else if (m0_read || m1_read) begin
        w = (m0_read && m1_read) ? prefer : (m0_read ? 0 : 1);
        serving = w; prefer = 1 - w; exp_wr[w] = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (model_ready) begin
      checkOutput("m0_waitrequest", 32'(m0_waitrequest), 32'(exp_wr[0]));
      checkOutput("m1_waitrequest", 32'(m1_waitrequest), 32'(exp_wr[1]));
      checkOutput("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp_rdv[0]));
      checkOutput("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp_rdv[1]));
      checkOutput("m0_readdata", m0_readdata, exp_rd[0]);
      checkOutput("m1_readdata", m1_readdata, exp_rd[1]);
      checkOutput("sys_address", 32'(sys_address), 32'(exp_addr()));
      checkOutput("id_word0", id_word0, exp_word[0]);
      checkOutput("id_word1", id_word1, exp_word[1]);
      checkOutput("id_valid", 32'(id_valid), 32'(exp_valid));
      checkOutput("id_mismatch", 32'(id_mismatch), 32'(exp_mis));
    end
  end

  task automatic applyStimulus(input bit rst, input bit rc, input bit r0, input bit a0,
                               input bit r1, input bit a1);
    #1;
    reset = rst; recheck = rc;
    m0_read = r0; m0_address = a0; m1_read = r1; m1_address = a1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    bit r0, a0, r1, a1;
    slave_word[0] = EXP0; slave_word[1] = EXP1;
    reset = 1; recheck = 0; m0_read = 0; m0_address = 0; m1_read = 0; m1_address = 0;
    nextCycle(); nextCycle();

    // Reset release: ID check completes two edges later.
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("lit_valid_c1", 32'(id_valid), 32'd0);
    checkOutput("lit_wr_c1", 32'(m0_waitrequest), 32'd1);
    nextCycle();
    checkOutput("lit_valid_c2", 32'(id_valid), 32'd1);
    checkOutput("lit_mis_c2", 32'(id_mismatch), 32'd0);
    checkOutput("lit_word1_c2", id_word1, 32'h5547_181E);

    // Single m0 read of address 1.
    applyStimulus(0, 0, 1, 1, 0, 0);
    nextCycle();
    checkOutput("lit_m0_wr_low", 32'(m0_waitrequest), 32'd0);
    checkOutput("lit_m1_wr_high", 32'(m1_waitrequest), 32'd1);
    nextCycle();
    checkOutput("lit_m0_rdv", 32'(m0_readdatavalid), 32'd1);
    checkOutput("lit_m0_rd", m0_readdata, 32'h5547_181E);
    checkOutput("lit_m1_rd_quiet", {m1_readdata[30:0], m1_readdatavalid}, 32'd0);

    // Wrong word1 then restore, each with a recheck.
    applyStimulus(0, 1, 0, 0, 0, 0);
    slave_word[1] = 32'h1234_5678;
    nextCycle();
    checkOutput("lit_valid_drop", 32'(id_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle(); nextCycle();
    checkOutput("lit_bad_valid", 32'(id_valid), 32'd1);
    checkOutput("lit_bad_mis", 32'(id_mismatch), 32'd1);
    checkOutput("lit_bad_word1", id_word1, 32'h1234_5678);
    applyStimulus(0, 1, 0, 0, 0, 0);
    slave_word[1] = EXP1;
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle();
    checkOutput("lit_valid_low2", 32'(id_valid), 32'd0);
    nextCycle();
    checkOutput("lit_good_mis", 32'(id_mismatch), 32'd0);

    // Both masters hold reads: m0 won last, so m1 goes first, then alternate.
    applyStimulus(0, 0, 1, 0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      nextCycle();
      if (k % 2 == 0)
        checkOutput("lit_rr_order", {30'd0, m1_readdatavalid, m0_readdatavalid},
                    (k % 4 == 2) ? 32'd2 : 32'd1);
    end

    // Recheck during m1's service: m1 completes, check runs before m0 is granted.
    nextCycle();
    checkOutput("lit_m1_granted", 32'(m1_waitrequest), 32'd0);
    applyStimulus(0, 1, 1, 0, 1, 1);
    nextCycle();
    checkOutput("lit_m1_done", 32'(m1_readdatavalid), 32'd1);
    checkOutput("lit_m1_data", m1_readdata, 32'h5547_181E);
    applyStimulus(0, 0, 1, 0, 0, 0);
    nextCycle();
    checkOutput("lit_chk_first", {30'd0, id_valid, m0_waitrequest}, 32'd1);
    nextCycle(); nextCycle();
    checkOutput("lit_chk_done", {30'd0, id_valid, m0_waitrequest}, 32'd3);
    nextCycle();
    checkOutput("lit_m0_after_chk", 32'(m0_waitrequest), 32'd0);
    nextCycle();
    checkOutput("lit_m0_after_rdv", 32'(m0_readdatavalid), 32'd1);

    // Reset during SERVE kills the read and restarts the check.
    applyStimulus(0, 0, 1, 1, 0, 0);
    nextCycle();
    checkOutput("lit_serve_before_rst", 32'(m0_waitrequest), 32'd0);
    applyStimulus(1, 0, 1, 1, 0, 0);
    nextCycle();
    checkOutput("lit_rst_state", {29'd0, m0_readdatavalid, m0_waitrequest, id_valid}, 32'd2);
    applyStimulus(0, 0, 0, 0, 0, 0);
    nextCycle(); nextCycle();
    checkOutput("lit_rst_rechk", 32'(id_valid), 32'd1);

    // Random traffic; masters hold only while granted and may withdraw otherwise.
    for (int c = 0; c < 4000; c++) begin
      r0 = m0_waitrequest ? ($urandom_range(0, 2) != 0) : 1'b1;
      a0 = m0_waitrequest ? 1'($urandom_range(0, 1)) : m0_address;
      r1 = m1_waitrequest ? ($urandom_range(0, 2) != 0) : 1'b1;
      a1 = m1_waitrequest ? 1'($urandom_range(0, 1)) : m1_address;
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, r0, a0, r1, a1);
      if ($urandom_range(0, 49) == 0)
        slave_word[$urandom_range(0, 1)] = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0;
      if ($urandom_range(0, 49) == 0) slave_word[1] = EXP1;
      nextCycle();
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
